// File: rtl/unpacked_mx_flush_fifo.sv
// unpacked_mx_flush_fifo: FIFO of atomic (mantissa block, shared exponent) entries with synchronous flush.
// Define UNPACKED_MX_FIFO_BYPASS_EN for a same-cycle empty-FIFO bypass.
module unpacked_mx_flush_fifo #(
  parameter int DEPTH = 8,
  parameter int MAN_WIDTH = 8,
  parameter int EXP_WIDTH = 8,
  parameter int IN_SIZE = 8,
  parameter int AF_THRESH = DEPTH - 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MAN_WIDTH-1:0] mdata_in [IN_SIZE],
  input  logic [EXP_WIDTH-1:0] edata_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [MAN_WIDTH-1:0] mdata_out [IN_SIZE],
  output logic [EXP_WIDTH-1:0] edata_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  input  logic                 flush,
  output logic [CW-1:0]        count,
  output logic                 almost_full,
  output logic                 empty,
  output logic                 full
);
  logic [MAN_WIDTH-1:0] man_q [DEPTH][IN_SIZE];
  logic [EXP_WIDTH-1:0] exp_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop, bypass;
  always_comb begin
    count = count_q;
    empty = count_q == '0;
    full = count_q == CW'(DEPTH);
    almost_full = count_q >= CW'(AF_THRESH);
`ifdef UNPACKED_MX_FIFO_BYPASS_EN
    bypass = rst && empty && data_in_valid && data_out_ready && !flush;
`else
    bypass = 1'b0;
`endif
    // rst gates ready so the port reads 0 for the whole time reset is held
    data_in_ready = rst && !full;
    data_out_valid = !empty || bypass;
    push = data_in_valid && data_in_ready && !flush && !bypass;
    pop = !empty && data_out_ready && !flush;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    edata_out = bypass ? edata_in : data_out_valid ? exp_q[rd_ptr_q] : '0;
    for (int i = 0; i < IN_SIZE; i++)
      mdata_out[i] = bypass ? mdata_in[i] : data_out_valid ? man_q[rd_ptr_q][i] : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // storage is deliberately not reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (push) begin
      man_q[wr_ptr_q] <= mdata_in;
      exp_q[wr_ptr_q] <= edata_in;
    end
  end
endmodule
